// File: rtl/cfg_reg_file.sv
// -----------------------------------------------------------------------------
// cfg_reg_file
//
// Synchronous register file of N_REGS registers, DATA_W bits each, sitting
// between the host command decoder and the controller datapath. Every
// register is exported in parallel on regs_out.
//
// Per-register access modes, selected at elaboration time:
//   RW  : byte-lane writes through wstrb.
//   RO  : captures hw_in every cycle; host writes are rejected with err.
//   W1C : next = (cur & ~clr) | set. The host clears bits by writing ones.
//         hw_set sets bits every cycle, and set wins over clear.
//   RO takes priority when a register is marked both RO and W1C.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   req, we    single-cycle access request, 1 = write
//   addr       register index
//   wstrb      byte-lane write enables
//   wdata      write data
//   rdata      registered read data (0 on write acks and invalid reads)
//   ack        one-cycle pulse one cycle after every req
//   err        qualified by ack: address out of range, or write to RO
//   hw_in      per-register status inputs for RO registers (flat, slice i)
//   hw_set     per-bit set requests for W1C registers (flat, slice i)
//   regs_out   current register contents (flat, slice i)
//   wr_pulse   one-cycle pulse per register after an accepted write
// -----------------------------------------------------------------------------
module cfg_reg_file #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 7,
    parameter int                 N_REGS   = 128,
    parameter logic [N_REGS-1:0]  RO_MASK  = '0,
    parameter logic [N_REGS-1:0]  W1C_MASK = '0,
    parameter logic [DATA_W-1:0]  RST_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W/8-1:0]        wstrb,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       ack,
    output logic                       err,
    input  logic [N_REGS*DATA_W-1:0]   hw_in,
    input  logic [N_REGS*DATA_W-1:0]   hw_set,
    output logic [N_REGS*DATA_W-1:0]   regs_out,
    output logic [N_REGS-1:0]          wr_pulse
);

    localparam int N_LANES = DATA_W / 8;

    logic [DATA_W-1:0] lane_mask;
    logic [N_REGS-1:0] sel;
    logic [N_REGS-1:0] wr_acc;
    logic              addr_valid;
    logic              ro_hit;
    logic              err_next;
    logic [DATA_W-1:0] rd_mux;

    // Each byte-lane enable is widened to a full bit mask.
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < N_LANES; b++) begin
            lane_mask[b*8 +: 8] = {8{wstrb[b]}};
        end
    end

    // One-hot decode. An address at or above N_REGS matches no register, so an
    // all-zero select vector marks an out-of-range access.
    for (genvar i = 0; i < N_REGS; i++) begin : g_dec
        assign sel[i] = (addr == ADDR_W'(i));
    end

    assign addr_valid = |sel;
    assign ro_hit     = |(sel & RO_MASK);
    assign wr_acc     = {N_REGS{req & we}} & sel & ~RO_MASK;
    assign err_next   = req & (~addr_valid | (we & ro_hit));

    // Read mux over the pre-edge register values, which keeps same-cycle
    // hardware updates out of the returned data.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (sel[i]) begin
                rd_mux = rd_mux | regs_out[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register storage, one generate branch per access mode.
    // NOTE: every register is reset, not just the control flops, because all
    // of them are exported on regs_out and downstream logic must never see X.
    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        logic [DATA_W-1:0] q;

        if (RO_MASK[i]) begin : g_ro
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else begin
                    q <= hw_in[i*DATA_W +: DATA_W];
                end
            end
        end else if (W1C_MASK[i]) begin : g_w1c
            logic [DATA_W-1:0] clr;
            assign clr = wr_acc[i] ? (wdata & lane_mask) : '0;

            // OR-ing hw_set after the clear makes set win on a shared bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= RST_VAL;
                end else begin
                    q <= (q & ~clr) | hw_set[i*DATA_W +: DATA_W];
                end
            end
        end else begin : g_rw
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= RST_VAL;
                end else if (wr_acc[i]) begin
                    q <= (q & ~lane_mask) | (wdata & lane_mask);
                end
            end
        end

        assign regs_out[i*DATA_W +: DATA_W] = q;
    end

    // Response stage: every request is answered exactly one cycle later.
    // NOTE: sequential state is assigned with non-blocking (<=) so all flops
    // sample their inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack      <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            wr_pulse <= '0;
        end else begin
            ack      <= req;
            err      <= err_next;
            wr_pulse <= wr_acc;
            // rdata only moves on a request; it holds between accesses.
            if (req) begin
                rdata <= (!we && addr_valid) ? rd_mux : '0;
            end
        end
    end

    // Status/set bits of registers in the other modes have no consumer.
    logic unused_inputs;
    assign unused_inputs = ^{hw_in, hw_set};

endmodule

// File: tb/tb_cfg_reg_file.sv
// -----------------------------------------------------------------------------
// tb_cfg_reg_file
//
// Directed bench for cfg_reg_file with DATA_W=32, N_REGS=100,
// RST_VAL=32'hA5A5A5A5. Register 2 is RO (also marked W1C, so RO must win),
// register 5 is W1C, and all others are RW.
// -----------------------------------------------------------------------------
module tb_cfg_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;
    localparam int N_REGS = 100;
    localparam logic [N_REGS-1:0] RO_MASK  = N_REGS'(1) << 2;
    localparam logic [N_REGS-1:0] W1C_MASK = (N_REGS'(1) << 5) | (N_REGS'(1) << 2);
    localparam logic [DATA_W-1:0] RST_VAL  = 32'hA5A5A5A5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      req;
    logic                      we;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W/8-1:0]       wstrb;
    logic [DATA_W-1:0]         wdata;
    logic [DATA_W-1:0]         rdata;
    logic                      ack;
    logic                      err;
    logic [N_REGS*DATA_W-1:0]  hw_in;
    logic [N_REGS*DATA_W-1:0]  hw_set;
    logic [N_REGS*DATA_W-1:0]  regs_out;
    logic [N_REGS-1:0]         wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    cfg_reg_file #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .N_REGS  (N_REGS),
        .RO_MASK (RO_MASK),
        .W1C_MASK(W1C_MASK),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .rdata   (rdata),
        .ack     (ack),
        .err     (err),
        .hw_in   (hw_in),
        .hw_set  (hw_set),
        .regs_out(regs_out),
        .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] reg_at(input int i);
        return regs_out[i*DATA_W +: DATA_W];
    endfunction

    // Advance one rising edge; outputs are then sampled 1 ns after it and
    // inputs changed at the same point stay stable through the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic w, input int a, input logic [3:0] s, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        addr  = ADDR_W'(a);
        wstrb = s;
        wdata = d;
    endtask

    task automatic idle();
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wstrb = '0;
        wdata = '0;
    endtask

    int          b2b_addr [4] = '{120, 3, 99, 101};
    logic        b2b_err  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] b2b_data [4] = '{32'h0, 32'hA522A544, 32'hA5A5A5A5, 32'h0};

    initial begin
        hw_in  = '0;
        hw_set = '0;

        // Reset held two cycles with a request pending: it must be dropped.
        rst = 1'b1;
        set_req(1'b0, 3, 4'h0, 32'h0);
        tick();
        tick();
        check("rst_ack",   ack, 1'b0);
        check("rst_err",   err, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_wp",    wr_pulse, '0);
        check("rst_rw0",   reg_at(0), 32'hA5A5A5A5);
        check("rst_rw99",  reg_at(99), 32'hA5A5A5A5);
        check("rst_w1c5",  reg_at(5), 32'hA5A5A5A5);
        check("rst_ro2",   reg_at(2), 32'h0);
        rst = 1'b0;
        idle();
        tick();
        check("post_rst_ack", ack, 1'b0);

        // Byte strobes on RW register 3.
        set_req(1'b1, 3, 4'b0101, 32'h11223344);
        tick();
        check("bs_ack",   ack, 1'b1);
        check("bs_err",   err, 1'b0);
        check("bs_reg3",  reg_at(3), 32'hA522A544);
        check("bs_wp",    wr_pulse, 128'(1) << 3);
        check("bs_rdata", rdata, 32'h0);
        set_req(1'b0, 3, 4'h0, 32'h0);
        tick();
        check("bs_rd_ack",   ack, 1'b1);
        check("bs_rd_err",   err, 1'b0);
        check("bs_rd_data",  rdata, 32'hA522A544);
        check("bs_wp_clear", wr_pulse, '0);
        idle();
        tick();
        check("idle_ack",   ack, 1'b0);
        check("idle_rdata", rdata, 32'hA522A544);

        // Accepted write with no lanes enabled: pulse, no data change.
        set_req(1'b1, 7, 4'b0000, 32'hFFFFFFFF);
        tick();
        check("zs_wp",   wr_pulse, 128'(1) << 7);
        check("zs_err",  err, 1'b0);
        check("zs_reg7", reg_at(7), 32'hA5A5A5A5);

        // W1C register 5: clear everything, hardware set, software clear.
        set_req(1'b1, 5, 4'hF, 32'hFFFFFFFF);
        tick();
        check("w1c_clrall", reg_at(5), 32'h0);
        check("w1c_wp",     wr_pulse, 128'(1) << 5);
        idle();
        hw_set[5*DATA_W +: DATA_W] = 32'h0F;
        tick();
        hw_set = '0;
        check("w1c_set", reg_at(5), 32'h0F);
        set_req(1'b1, 5, 4'hF, 32'h03);
        tick();
        check("w1c_clr", reg_at(5), 32'h0C);
        set_req(1'b1, 5, 4'hF, 32'h01);
        hw_set[5*DATA_W +: DATA_W] = 32'h01;
        tick();
        hw_set = '0;
        check("w1c_setwins", reg_at(5), 32'h0D);
        // Clear restricted to lane 1 leaves the low byte intact.
        set_req(1'b1, 5, 4'b0010, 32'hFFFFFFFF);
        tick();
        check("w1c_lane", reg_at(5), 32'h0D);

        // RO register 2 (RO wins over its W1C marking).
        idle();
        hw_in[2*DATA_W +: DATA_W] = 32'h5A;
        hw_set[2*DATA_W +: DATA_W] = 32'hF0;
        tick();
        hw_set = '0;
        check("ro_cap", reg_at(2), 32'h5A);
        set_req(1'b1, 2, 4'hF, 32'hFF);
        tick();
        check("ro_wr_ack", ack, 1'b1);
        check("ro_wr_err", err, 1'b1);
        check("ro_wr_wp",  wr_pulse, '0);
        check("ro_hold",   reg_at(2), 32'h5A);
        // Read in the same cycle hw_in changes returns the pre-edge value.
        set_req(1'b0, 2, 4'h0, 32'h0);
        hw_in[2*DATA_W +: DATA_W] = 32'h77;
        tick();
        check("ro_rd_data", rdata, 32'h5A);
        check("ro_rd_err",  err, 1'b0);
        check("ro_new",     reg_at(2), 32'h77);

        // Out of range and boundary addresses.
        set_req(1'b0, 120, 4'h0, 32'h0);
        tick();
        check("oor_rd_ack",   ack, 1'b1);
        check("oor_rd_err",   err, 1'b1);
        check("oor_rd_rdata", rdata, 32'h0);
        set_req(1'b1, 100, 4'hF, 32'h12345678);
        tick();
        check("oor_wr_err", err, 1'b1);
        check("oor_wr_wp",  wr_pulse, '0);
        set_req(1'b0, 99, 4'h0, 32'h0);
        tick();
        check("last_rd_err",  err, 1'b0);
        check("last_rd_data", rdata, 32'hA5A5A5A5);

        // Back-to-back requests: one ack per request, each with its own result.
        for (int k = 0; k < 4; k++) begin
            set_req(1'b0, b2b_addr[k], 4'h0, 32'h0);
            tick();
            check($sformatf("b2b%0d_ack", k),  ack, 1'b1);
            check($sformatf("b2b%0d_err", k),  err, b2b_err[k]);
            check($sformatf("b2b%0d_data", k), rdata, b2b_data[k]);
        end
        idle();
        tick();
        check("b2b_end_ack", ack, 1'b0);

        // Reset mid-burst: write acks, the following read collides with reset.
        set_req(1'b1, 4, 4'hF, 32'h12345678);
        tick();
        check("mb_wr_ack", ack, 1'b1);
        check("mb_wr_wp",  wr_pulse, 128'(1) << 4);
        check("mb_reg4",   reg_at(4), 32'h12345678);
        set_req(1'b0, 4, 4'h0, 32'h0);
        rst = 1'b1;
        hw_set[5*DATA_W +: DATA_W] = 32'hFF00;
        tick();
        check("mb_rst_ack",   ack, 1'b0);
        check("mb_rst_err",   err, 1'b0);
        check("mb_rst_rdata", rdata, 32'h0);
        check("mb_rst_wp",    wr_pulse, '0);
        check("mb_rst_reg4",  reg_at(4), 32'hA5A5A5A5);
        check("mb_rst_reg5",  reg_at(5), 32'hA5A5A5A5);
        check("mb_rst_reg2",  reg_at(2), 32'h0);
        rst = 1'b0;
        hw_set = '0;
        idle();
        tick();
        check("mb_after_ack", ack, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
